seq_player: RTL and testbench
=============================

SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 5, width of the sequence memory address and of `last`.
- TB_W, 6, width of the `timebase` duration.

REQ-002 The block SHALL have these ports:
- clock  in  1  rising-edge system clock.
- rst_n  in  1  reset.
- start  in  1  playback request, sampled in IDLE.
- abort  in  1  cancels playback.
- last  in  ADDR_W  index of the final sequence element to play.
- timebase  in  TB_W  count for both the LED-on and the LED-off phase.
- mem_rd  out  1  sequence memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_data  in  2  colour code, valid the cycle after mem_rd.
- play  out  1  tone generator enable.
- sound  out  3  tone code.
- nl  out  4  one-hot key LEDs.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

REQ-003 The block SHALL use one clock, `clock`; reset SHALL be asynchronous and active-low on `rst_n`.

Function
REQ-004 The FSM SHALL have states IDLE, RD, CAP, ON, OFF and FIN; all outputs SHALL be registered.

REQ-005 IDLE: if start=1 and abort=0, the block SHALL latch last→L and timebase→T, set idx=0, and go to RD; otherwise it stays in IDLE.

REQ-006 RD: mem_rd=1 and mem_addr=idx for exactly this cycle; next state CAP.

REQ-007 CAP: the block SHALL capture mem_data as d, set sound={1'b0,d}, play=1, nl[d]=1 (all other nl bits 0) and count=T, effective from the next cycle; next state ON.

REQ-008 ON: if count≠0, the block SHALL decrement count and stay in ON; if count=0, it SHALL set play=0, nl=0 and count=T, and go to OFF.

REQ-009 ON SHALL last T+1 cycles, and play SHALL be high for exactly those cycles.

REQ-010 OFF: if count≠0, the block SHALL decrement count; if count=0 and idx=L, it SHALL go to FIN; if count=0 and idx≠L, it SHALL set idx=idx+1 and go to RD.

REQ-011 OFF SHALL last T+1 cycles.

REQ-012 FIN: done=1 for this single cycle; next state IDLE.

REQ-013 busy SHALL be 1 in RD, CAP, ON, OFF and FIN, and 0 in IDLE.

REQ-014 Per-element period SHALL be 2T+4 cycles.

REQ-015 With start accepted at cycle 0, the first mem_rd SHALL occur at cycle 1 and done SHALL occur at cycle 1+(L+1)(2T+4).

REQ-016 T=0 SHALL give 1-cycle ON and 1-cycle OFF phases; count SHALL never underflow.

REQ-017 L=2^ADDR_W−1 SHALL play all 32 elements; idx SHALL never wrap past L, and no read SHALL follow index 31.

REQ-018 start while busy SHALL be ignored.

REQ-019 Changes to last or timebase after acceptance SHALL have no effect until the next accepted start.

REQ-020 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with play=0, nl=0, mem_rd=0 and no done pulse.

REQ-021 abort and start asserted together in IDLE: abort SHALL win and start SHALL be ignored.

REQ-022 A start SHALL be accepted in the cycle immediately after an abort or after FIN.

REQ-023 sound SHALL hold its last value while play=0.

Reset
REQ-024 rst_n=0 SHALL immediately, asynchronously set state=IDLE and idx=0, count=0, L=0, T=0.

REQ-025 rst_n=0 SHALL immediately, asynchronously set mem_rd=0, mem_addr=0, play=0, sound=0, nl=0, busy=0 and done=0.

REQ-026 Reset asserted mid-playback SHALL discard the sequence; after release, the block SHALL wait for a new start.

Verification
REQ-027 Single element: L=0, T=2, mem[0]=2, start at cycle 0 → mem_rd/addr 0 at cycle 1; play=1, sound=2, nl=0100 in cycles 3–5; play=0, nl=0 in cycles 6–8; done at cycle 9.

REQ-028 Multi-element: L=2, T=0, mem={1,3,0} → mem_rd at cycles 1, 5 and 9 with addr 0, 1, 2; nl=0010, 1000, 0001 in turn; done at cycle 13.

REQ-029 Full length: L=31, T=0 → 32 reads at addr 0..31 only; done at cycle 129; no read of addr 0 after addr 31.

REQ-030 Abort: abort during ON of element 1 → next cycle busy=0, play=0, nl=0, no done; start on the following cycle restarts from addr 0.

REQ-031 Ignored inputs: start re-pulsed and timebase changed to 5 while playing with T=1 → ON and OFF stay 2 cycles each; no restart.

REQ-032 Reset mid-ON: rst_n low during ON → play, nl, busy and done all 0 before the next clock edge; idle after release.

Source files
------------

// File: rtl/seq_player_if.sv
// Sequence-memory read port: a one-cycle read strobe with address, and
// two-bit colour data returned on the cycle after the strobe.
interface seq_player_if #(
  parameter int ADDR_W = 5
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/seq_player.sv
// Plays a stored colour sequence: each element lights one key LED and its tone
// for T+1 cycles, then stays dark for T+1 cycles before the next element is fetched.
module seq_player #(
  parameter int ADDR_W = 5,
  parameter int TB_W   = 6
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last,
  input  logic [TB_W-1:0]   timebase,
  seq_player_if.master      mem,
  output logic              play,
  output logic [2:0]        sound,
  output logic [3:0]        nl,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_ON   = 3'd3,
    S_OFF  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [TB_W-1:0]   CNT_ZERO = {TB_W{1'b0}};
  localparam logic [TB_W-1:0]   CNT_ONE  = {{(TB_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] last_r;
  logic [TB_W-1:0]   tb_r;
  logic [TB_W-1:0]   cnt_r;

  function automatic logic [3:0] led_decode(input logic [1:0] code);
    logic [3:0] leds;
    case (code)
      2'd0:    leds = 4'b0001;
      2'd1:    leds = 4'b0010;
      2'd2:    leds = 4'b0100;
      2'd3:    leds = 4'b1000;
      default: leds = 4'b0000;
    endcase
    return leds;
  endfunction

  // Playback sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      idx_r        <= IDX_ZERO;
      last_r       <= IDX_ZERO;
      tb_r         <= CNT_ZERO;
      cnt_r        <= CNT_ZERO;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= IDX_ZERO;
      play         <= 1'b0;
      sound        <= 3'd0;
      nl           <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      mem.mem_rd <= 1'b0;
      done       <= 1'b0;
      if (abort && (state_r != S_IDLE)) begin
        // sound is left untouched so it keeps its last tone code
        state_r <= S_IDLE;
        play    <= 1'b0;
        nl      <= 4'd0;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start && !abort) begin
              last_r       <= last;
              tb_r         <= timebase;
              idx_r        <= IDX_ZERO;
              mem.mem_addr <= IDX_ZERO;
              mem.mem_rd   <= 1'b1;
              busy         <= 1'b1;
              state_r      <= S_RD;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_RD: begin
            state_r <= S_CAP;
          end
          S_CAP: begin
            sound   <= {1'b0, mem.mem_data};
            play    <= 1'b1;
            nl      <= led_decode(mem.mem_data);
            cnt_r   <= tb_r;
            state_r <= S_ON;
          end
          S_ON: begin
            if (cnt_r != CNT_ZERO) begin
              cnt_r <= cnt_r - CNT_ONE;
            end else begin
              play    <= 1'b0;
              nl      <= 4'd0;
              cnt_r   <= tb_r;
              state_r <= S_OFF;
            end
          end
          S_OFF: begin
            if (cnt_r != CNT_ZERO) begin
              cnt_r <= cnt_r - CNT_ONE;
            end else if (idx_r == last_r) begin
              done    <= 1'b1;
              state_r <= S_FIN;
            end else begin
              idx_r        <= idx_r + IDX_ONE;
              mem.mem_addr <= idx_r + IDX_ONE;
              mem.mem_rd   <= 1'b1;
              state_r      <= S_RD;
            end
          end
          S_FIN: begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            play    <= 1'b0;
            nl      <= 4'd0;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: expected reads, LED phases and done pulses are
// queued when playback is started and retired as the DUT produces them.
module tb_seq_player;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] last = 5'd0;
  logic [5:0] timebase = 6'd0;
  logic       play;
  logic [2:0] sound;
  logic [3:0] nl;
  logic       busy;
  logic       done;

  seq_player_if #(.ADDR_W(5)) mbus ();

  seq_player #(.ADDR_W(5), .TB_W(6)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .last     (last),
    .timebase (timebase),
    .mem      (mbus),
    .play     (play),
    .sound    (sound),
    .nl       (nl),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  typedef struct {int cyc; logic [4:0] addr;} rd_t;
  typedef struct {int cyc; logic [3:0] leds; logic [2:0] snd;} led_t;

  rd_t  rd_q[$];
  led_t led_q[$];
  int   done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int on_start = 0;
  int last_on_len = 0;
  logic prev_play = 1'b0;
  logic [1:0] mem_arr [32];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Sequence memory: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (mbus.mem_rd) mbus.mem_data <= mem_arr[mbus.mem_addr];
  end

  // Output monitor retiring scoreboard entries.
  always @(negedge clock) begin
    rd_t  r;
    led_t l;
    int   d;
    if (rst_n) begin
      if (mbus.mem_rd) begin
        if (rd_q.size() == 0) begin
          check_eq("rd_unexpected", {27'd0, mbus.mem_addr}, 32'hffff_ffff);
        end else begin
          r = rd_q.pop_front();
          check_eq("rd_cycle", cyc, r.cyc);
          check_eq("rd_addr", {27'd0, mbus.mem_addr}, {27'd0, r.addr});
          check_eq("rd_busy", {31'd0, busy}, 32'd1);
        end
      end
      if (play && !prev_play) begin
        on_start = cyc;
        if (led_q.size() == 0) begin
          check_eq("play_unexpected", 32'd1, 32'd0);
        end else begin
          l = led_q.pop_front();
          check_eq("on_cycle", cyc, l.cyc);
          check_eq("on_nl", {28'd0, nl}, {28'd0, l.leds});
          check_eq("on_sound", {29'd0, sound}, {29'd0, l.snd});
        end
      end
      if (!play && prev_play) begin
        last_on_len = cyc - on_start;
        check_eq("off_nl", {28'd0, nl}, 32'd0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          check_eq("done_cycle", cyc, d);
        end
      end
      prev_play = play;
    end else begin
      prev_play = 1'b0;
    end
  end

  // Drive a start for one cycle and queue what the playback should produce.
  task automatic start_seq(input int l, input int t, input int n_elems, input bit exp_done);
    int c;
    int period;
    rd_t r;
    led_t e;
    @(negedge clock);
    c = cyc;
    period = 2 * t + 4;
    last = l[4:0];
    timebase = t[5:0];
    start = 1'b1;
    for (int k = 0; k < n_elems; k++) begin
      r.cyc = c + 1 + k * period;
      r.addr = k[4:0];
      rd_q.push_back(r);
      e.cyc = r.cyc + 2;
      e.leds = 4'b0001 << mem_arr[k];
      e.snd = {1'b0, mem_arr[k]};
      led_q.push_back(e);
    end
    if (exp_done) done_q.push_back(c + 1 + (l + 1) * period);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!busy && rd_q.size() == 0 && led_q.size() == 0 && done_q.size() == 0) return;
    end
    check_eq("idle_timeout", 32'd0, 32'd1);
    rd_q.delete();
    led_q.delete();
    done_q.delete();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 32; i++) mem_arr[i] = 2'(i % 4);

    // reset state
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_play", {31'd0, play}, 32'd0);
    check_eq("rst_nl", {28'd0, nl}, 32'd0);
    check_eq("rst_sound", {29'd0, sound}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_mem_rd", {31'd0, mbus.mem_rd}, 32'd0);
    check_eq("rst_mem_addr", {27'd0, mbus.mem_addr}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // single element, T=2
    mem_arr[0] = 2'd2;
    start_seq(0, 2, 1, 1'b1);
    wait_idle(40);
    check_eq("single_on_len", last_on_len, 32'd3);

    // three elements, T=0; restart right after FIN
    mem_arr[0] = 2'd1; mem_arr[1] = 2'd3; mem_arr[2] = 2'd0;
    start_seq(2, 0, 3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) break;
    end
    check_eq("multi_done_seen", {31'd0, done}, 32'd1);
    check_eq("multi_on_len", last_on_len, 32'd1);

    // full length, T=0, random colours, started the cycle after FIN
    for (int i = 0; i < 32; i++) mem_arr[i] = 2'($urandom_range(0, 3));
    start_seq(31, 0, 32, 1'b1);
    wait_idle(200);

    // start and abort together in IDLE: abort wins
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_start_rd", {31'd0, mbus.mem_rd}, 32'd0);

    // abort during ON of element 1 (T=2), then restart at once
    for (int i = 0; i < 4; i++) mem_arr[i] = 2'(3 - i);
    c = cyc + 1;
    start_seq(3, 2, 2, 1'b0);
    wait_until(c + 12);
    check_eq("pre_abort_play", {31'd0, play}, 32'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_play", {31'd0, play}, 32'd0);
    check_eq("abort_nl", {28'd0, nl}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    start = 1'b1;
    mem_arr[0] = 2'd2;
    c = cyc;
    rd_q.push_back('{cyc: c + 1, addr: 5'd0});
    led_q.push_back('{cyc: c + 3, leds: 4'b0100, snd: 3'd2});
    done_q.push_back(c + 5);
    last = 5'd0; timebase = 6'd0;
    @(negedge clock);
    start = 1'b0;
    wait_idle(30);

    // start re-pulsed and inputs changed while playing: no effect
    mem_arr[0] = 2'd0; mem_arr[1] = 2'd1;
    c = cyc + 1;
    start_seq(1, 1, 2, 1'b1);
    wait_until(c + 4);
    start = 1'b1; timebase = 6'd5; last = 5'd7;
    @(negedge clock);
    start = 1'b0;
    wait_idle(40);
    check_eq("ignored_on_len", last_on_len, 32'd2);

    // asynchronous reset during ON
    c = cyc + 1;
    start_seq(1, 3, 2, 1'b1);
    wait_until(c + 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_play", {31'd0, play}, 32'd0);
    check_eq("arst_nl", {28'd0, nl}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    rd_q.delete(); led_q.delete(); done_q.delete();
    @(negedge clock);
    rst_n = 1'b1;
    repeat (12) @(negedge clock);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("post_rst_play", {31'd0, play}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
